vga_timing_param: RTL and testbench
===================================

# vga_timing_param

Parametrised VGA timing generator that replaces the fixed-mode timing controller at the head of the video pipeline. Horizontal and vertical geometry, sync polarity and counter width are set by parameters. A pixel-rate clock enable lets the block run from the system clock. It also emits line-start and frame-start strobes, an active-video flag and a wrapping frame counter for downstream draw and game-logic blocks. It drives the same `vga_if_norgb` bundle as its predecessor, so existing consumers connect unchanged.

## Interface
Parameters:
- `H_ACTIVE`, 800: visible pixels per line.
- `H_FP`, 40: horizontal front porch, pixels.
- `H_SYNC`, 128: horizontal sync width, pixels.
- `H_BP`, 88: horizontal back porch, pixels.
- `V_ACTIVE`, 600: visible lines per frame.
- `V_FP`, 1: vertical front porch, lines.
- `V_SYNC`, 4: vertical sync width, lines.
- `V_BP`, 23: vertical back porch, lines.
- `HS_POL`, 1: hsync active level (1 = active high).
- `VS_POL`, 1: vsync active level (1 = active high).
- `CNT_W`, 11: width of hcount and vcount.
- `FRAME_CNT_W`, 8: frame counter width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `pix_en`  in  1  pixel-rate enable. Counters advance only on edges where it is 1.
- `out`  modport `vga_if_norgb.out`  —  `hcount`, `vcount` (CNT_W), `hsync`, `vsync`, `hblnk`, `vblnk`.
- `de`  out  1  active video: `!hblnk && !vblnk`.
- `line_start`  out  1  one-clk strobe when a new line begins.
- `frame_start`  out  1  one-clk strobe when a new frame begins.
- `frame_cnt`  out  FRAME_CNT_W  completed-frame counter.

## Operation
- Derived values:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
  - V_TOTAL is the vertical equivalent.
  - HS_START = H_ACTIVE + H_FP; HS_END = HS_START + H_SYNC. Vertical equivalents follow the same pattern.
- Elaboration-time `$error` if:
  - any geometry parameter is < 1,
  - H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W,
  - FRAME_CNT_W < 1.
- Advance on an edge with `pix_en=1`:
  - If hcount = H_TOTAL-1: hcount → 0, and vcount → 0 if vcount = V_TOTAL-1, otherwise vcount + 1.
  - Otherwise hcount + 1 and vcount holds.
- When `pix_en=0`, every output holds its value, except that the strobes drop to 0.
- Flags are decoded combinationally from the next count and registered, so every flag always matches the count it accompanies:
  - `hblnk` = hcount ≥ H_ACTIVE.
  - `hsync` = HS_POL when HS_START ≤ hcount < HS_END, otherwise !HS_POL.
  - `vblnk` and `vsync` are the vertical equivalents.
  - `de` = !hblnk && !vblnk.
- `line_start` = 1 for one clk after an advance that loads hcount = 0.
- `frame_start` = 1 for one clk after an advance that loads (hcount 0, vcount 0). It always coincides with a `line_start`.
- `frame_cnt` increments, wrapping modulo 2^FRAME_CNT_W, on the same edge that sets `frame_start`.

## Timing
- Reset values, on the edge after `rst` is sampled at 1:
  - hcount = 0, vcount = 0.
  - hblnk = 0, vblnk = 0, de = 1.
  - hsync = !HS_POL, vsync = !VS_POL.
  - line_start = 0, frame_start = 0, frame_cnt = 0.
- `rst` overrides `pix_en`. Reset mid-frame aborts the frame immediately; no strobe is produced for the aborted frame.
- The reset state is position (0, 0) of frame 0 with no strobes. The first `pix_en` advance after reset loads hcount = 1.
- Latency: outputs update on the same edge that samples `pix_en=1`. There is no extra pipeline stage.
- With `pix_en` tied to 1, the line period is H_TOTAL clks and the frame period is H_TOTAL·V_TOTAL clks.
- With `pix_en` at 1 every Nth clk, each count value is held for N clks. Strobes stay one clk wide.
- At the line wrap and the frame wrap, hcount, vcount and all flags update on the same edge. There are no intermediate glitch values.

## Test plan
Small geometry for all scenarios: H 8/2/2/2 (H_TOTAL = 14), V 4/1/1/1 (V_TOTAL = 7), `pix_en` = 1 unless noted.
1. Reset, then run 14 clks:
   - hcount steps 1..13 then 0; vcount steps 0 → 1 at the wrap.
   - hblnk = 1 exactly for hcount 8..13; hsync = 1 exactly for hcount 10..11.
   - line_start pulses once, aligned with hcount = 0.
2. Run 2 full frames (196 clks):
   - vblnk = 1 for vcount 4..6; vsync = 1 only for vcount 5.
   - frame_start pulses twice, 98 clks apart; frame_cnt reads 1 then 2.
   - de = 1 only for hcount < 8 and vcount < 4.
3. `pix_en` high every 3rd clk:
   - Each hcount value is held for 3 clks.
   - line_start stays 1 clk wide; the frame period is 294 clks.
4. HS_POL = 0, VS_POL = 0:
   - After reset, hsync = vsync = 1.
   - hsync = 0 only at hcount 10..11; vsync = 0 only at vcount 5.
5. Assert `rst` at hcount 6, vcount 2, frame_cnt 3:
   - Next clk: all outputs at reset values, frame_cnt = 0, no strobe.
   - After release, the first advance gives hcount = 1.
6. FRAME_CNT_W = 2, run 5 frames:
   - frame_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/vga_timing_param_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_if_norgb
// Brief    : VGA timing bundle (counts, syncs, blanking) without pixel data.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_if_norgb #(
    parameter int CNT_W = 11
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk
    );

    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_param.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_param
// Brief    : Parametrised VGA timing generator with pixel enable and strobes.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_param #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 128,
    parameter int H_BP        = 88,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 1,
    parameter int V_SYNC      = 4,
    parameter int V_BP        = 23,
    parameter int HS_POL      = 1,
    parameter int VS_POL      = 1,
    parameter int CNT_W       = 11,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_en,
    vga_if_norgb.out               out,
    output logic                   de,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HS_START = H_ACTIVE + H_FP;
    localparam int c_HS_END   = c_HS_START + H_SYNC;
    localparam int c_VS_START = V_ACTIVE + V_FP;
    localparam int c_VS_END   = c_VS_START + V_SYNC;

    localparam logic [CNT_W-1:0] c_H_LAST = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_S   = CNT_W'(c_HS_START);
    localparam logic [CNT_W-1:0] c_HS_E   = CNT_W'(c_HS_END);
    localparam logic [CNT_W-1:0] c_VS_S   = CNT_W'(c_VS_START);
    localparam logic [CNT_W-1:0] c_VS_E   = CNT_W'(c_VS_END);
    localparam logic             c_HS_ON  = (HS_POL != 0);
    localparam logic             c_VS_ON  = (VS_POL != 0);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_geom
            $error("vga_timing_param: every geometry parameter must be >= 1");
        end
        if (CNT_W < 1 || CNT_W > 62 ||
            64'(c_H_TOTAL - 1) >= (64'd1 << CNT_W) ||
            64'(c_V_TOTAL - 1) >= (64'd1 << CNT_W)) begin : g_chk_cnt_w
            $error("vga_timing_param: H_TOTAL-1 / V_TOTAL-1 do not fit in CNT_W");
        end
        if (FRAME_CNT_W < 1) begin : g_chk_frame_w
            $error("vga_timing_param: FRAME_CNT_W must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0]       hcount_q, hcount_d;
    logic [CNT_W-1:0]       vcount_q, vcount_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   hblnk_q, hblnk_d;
    logic                   vblnk_q, vblnk_d;
    logic                   de_q, de_d;
    logic                   line_start_q, line_start_d;
    logic                   frame_start_q, frame_start_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        if (pix_en) begin
            if (hcount_q == c_H_LAST) begin
                hcount_d     = '0;
                line_start_d = 1'b1;
                if (vcount_q == c_V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 1'b1;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end

        // Flags decode the next count so they register alongside it.
        hblnk_d = (hcount_d >= c_H_ACT);
        vblnk_d = (vcount_d >= c_V_ACT);
        hsync_d = ((hcount_d >= c_HS_S) && (hcount_d < c_HS_E)) ? c_HS_ON : !c_HS_ON;
        vsync_d = ((vcount_d >= c_VS_S) && (vcount_d < c_VS_E)) ? c_VS_ON : !c_VS_ON;
        de_d    = !hblnk_d && !vblnk_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= !c_HS_ON;
            vsync_q       <= !c_VS_ON;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign out.hcount  = hcount_q;
    assign out.vcount  = vcount_q;
    assign out.hsync   = hsync_q;
    assign out.vsync   = vsync_q;
    assign out.hblnk   = hblnk_q;
    assign out.vblnk   = vblnk_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vga_timing_param
// Brief    : Scoreboard bench for vga_timing_param on a 14x7 geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic pix_en;

    vga_if_norgb #(.CNT_W(4)) if_a ();
    vga_if_norgb #(.CNT_W(4)) if_b ();
    vga_if_norgb #(.CNT_W(4)) if_c ();

    logic       de_a, ls_a, fs_a;
    logic       de_b, ls_b, fs_b;
    logic       de_c, ls_c, fs_c;
    logic [7:0] fc_a, fc_b;
    logic [1:0] fc_c;

    // a: positive syncs, 8-bit frame count; b: negative syncs; c: 2-bit frame count
    vga_timing_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CNT_W(4), .FRAME_CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en), .out(if_a.out),
        .de(de_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CNT_W(4), .FRAME_CNT_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .pix_en(pix_en), .out(if_b.out),
        .de(de_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    vga_timing_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CNT_W(4), .FRAME_CNT_W(2)
    ) dut_c (
        .clk(clk), .rst(rst), .pix_en(pix_en), .out(if_c.out),
        .de(de_c), .line_start(ls_c), .frame_start(fs_c), .frame_cnt(fc_c)
    );

    typedef struct packed {
        logic [1:0]  inst;
        logic [22:0] exp;
    } sb_t;

    sb_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference position per instance
    int   mh [3];
    int   mv [3];
    int   mfc[3];
    logic mls[3];
    logic mfs[3];
    int   hpol [3] = '{1, 0, 1};
    int   vpol [3] = '{1, 0, 1};
    int   fcmod[3] = '{256, 256, 4};

    int cyc     = 0;
    int fs_cnt  = 0;
    int last_fs = -1;
    int fs_gap  = 0;
    int ls_run  = 0;
    int ls_max  = 0;

    // {hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start, frame_cnt}
    function automatic logic [22:0] exp_vec(input int i);
        logic hb, vb, hs, vs, d;
        hb = (mh[i] >= 8);
        vb = (mv[i] >= 4);
        hs = (mh[i] >= 10 && mh[i] < 12) ? (hpol[i] != 0) : (hpol[i] == 0);
        vs = (mv[i] == 5) ? (vpol[i] != 0) : (vpol[i] == 0);
        d  = !hb && !vb;
        return {4'(mh[i]), 4'(mv[i]), hs, vs, hb, vb, d, mls[i], mfs[i], 8'(mfc[i])};
    endfunction

    function automatic logic [22:0] dut_vec(input int i);
        case (i)
            0:       return {if_a.hcount, if_a.vcount, if_a.hsync, if_a.vsync,
                             if_a.hblnk, if_a.vblnk, de_a, ls_a, fs_a, fc_a};
            1:       return {if_b.hcount, if_b.vcount, if_b.hsync, if_b.vsync,
                             if_b.hblnk, if_b.vblnk, de_b, ls_b, fs_b, fc_b};
            default: return {if_c.hcount, if_c.vcount, if_c.hsync, if_c.vsync,
                             if_c.hblnk, if_c.vblnk, de_c, ls_c, fs_c, 6'd0, fc_c};
        endcase
    endfunction

    task automatic step(input logic r, input logic pe);
        sb_t e;
        logic [22:0] obs;
        rst    = r;
        pix_en = pe;
        for (int i = 0; i < 3; i++) begin
            mls[i] = 1'b0;
            mfs[i] = 1'b0;
            if (r) begin
                mh[i]  = 0;
                mv[i]  = 0;
                mfc[i] = 0;
            end else if (pe) begin
                if (mh[i] == 13) begin
                    mh[i]  = 0;
                    mls[i] = 1'b1;
                    if (mv[i] == 6) begin
                        mv[i]  = 0;
                        mfs[i] = 1'b1;
                        mfc[i] = (mfc[i] + 1) % fcmod[i];
                    end else begin
                        mv[i] = mv[i] + 1;
                    end
                end else begin
                    mh[i] = mh[i] + 1;
                end
            end
            sb.push_back('{inst: 2'(i), exp: exp_vec(i)});
        end
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = dut_vec(int'(e.inst));
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL out_%0d cyc=%0d observed=%h expected=%h", e.inst, cyc, obs, e.exp);
            end
        end
        if (ls_a) ls_run++; else ls_run = 0;
        if (ls_run > ls_max) ls_max = ls_run;
        if (fs_a) begin
            fs_cnt++;
            if (last_fs >= 0) fs_gap = cyc - last_fs;
            last_fs = cyc;
        end
    endtask

    task automatic clear_track();
        fs_cnt  = 0;
        last_fs = -1;
        fs_gap  = 0;
        ls_run  = 0;
        ls_max  = 0;
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        pix_en = 1'b0;

        // Reset state, then one line
        step(1'b1, 1'b0);
        for (int k = 0; k < 14; k++) step(1'b0, 1'b1);

        // Two full frames with continuous enable
        clear_track();
        for (int k = 0; k < 196; k++) step(1'b0, 1'b1);
        check_int("fs_count_2frames", fs_cnt, 2);
        check_int("fs_gap_2frames", fs_gap, 98);
        check_int("ls_width_2frames", ls_max, 1);

        // Enable on every third clock
        step(1'b1, 1'b1);
        clear_track();
        for (int k = 0; k < 588; k++) step(1'b0, (k % 3) == 2);
        check_int("fs_count_div3", fs_cnt, 2);
        check_int("fs_gap_div3", fs_gap, 294);
        check_int("ls_width_div3", ls_max, 1);

        // Mid-frame reset at (6, 2) of frame 3
        step(1'b1, 1'b0);
        for (int k = 0; k < 328; k++) step(1'b0, 1'b1);
        check_int("pre_reset_hcount", int'(if_a.hcount), 6);
        check_int("pre_reset_vcount", int'(if_a.vcount), 2);
        check_int("pre_reset_fcnt", int'(fc_a), 3);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check_int("first_adv_hcount", int'(if_a.hcount), 1);

        // Narrow frame counter wrap over five frames
        step(1'b1, 1'b0);
        for (int k = 0; k < 490; k++) step(1'b0, 1'b1);
        check_int("fc2_after_5frames", int'(fc_c), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
